// File: rtl/debouncer_if.sv
// Level-conditioning bus: the raw asynchronous level going in, and the clean
// level plus edge pulses coming back out.
interface debouncer_if;
  logic in_raw;
  logic out;
  logic rise;
  logic fall;

  modport master (output in_raw, input out, rise, fall);
  modport slave  (input in_raw, output out, rise, fall);
endinterface

// File: rtl/debouncer.sv
// Synchronizes a raw level, then qualifies it over STABLE_CYCLES consecutive
// samples before flipping the registered output and pulsing rise/fall.
module debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  debouncer_if.slave bus
);

  localparam int unsigned    CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam bit             SINGLE   = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    RISING      = 2'd1,
    STABLE_HIGH = 2'd2,
    FALLING     = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   in_sync;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_reg, out_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;

  // in_raw touches nothing but the first flop of this chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.in_raw};
    end
  end

  assign in_sync = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= STABLE_LOW;
      cnt_reg   <= CNT_ZERO;
      out_reg   <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;

    case (state_reg)
      STABLE_LOW: begin
        if (in_sync) begin
          // A one-sample window qualifies on the very first disagreeing sample.
          if (SINGLE) begin
            state_next = STABLE_HIGH;
            out_next   = 1'b1;
            rise_next  = 1'b1;
            cnt_next   = CNT_ZERO;
          end else begin
            state_next = RISING;
            cnt_next   = CNT_ONE;
          end
        end
      end

      RISING: begin
        if (!in_sync) begin
          state_next = STABLE_LOW;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = STABLE_HIGH;
          out_next   = 1'b1;
          rise_next  = 1'b1;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      STABLE_HIGH: begin
        if (!in_sync) begin
          if (SINGLE) begin
            state_next = STABLE_LOW;
            out_next   = 1'b0;
            fall_next  = 1'b1;
            cnt_next   = CNT_ZERO;
          end else begin
            state_next = FALLING;
            cnt_next   = CNT_ONE;
          end
        end
      end

      FALLING: begin
        if (in_sync) begin
          state_next = STABLE_HIGH;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = STABLE_LOW;
          out_next   = 1'b0;
          fall_next  = 1'b1;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = STABLE_LOW;
        cnt_next   = CNT_ZERO;
        out_next   = 1'b0;
      end
    endcase
  end

  assign bus.out  = out_reg;
  assign bus.rise = rise_reg;
  assign bus.fall = fall_reg;

  // Structural invariants of the qualifier.
  assert property (@(posedge clk) disable iff (!rst) !(rise_reg && fall_reg));
  assert property (@(posedge clk) disable iff (!rst) rise_reg |=> !rise_reg);
  assert property (@(posedge clk) disable iff (!rst) fall_reg |=> !fall_reg);
  assert property (@(posedge clk) disable iff (!rst) cnt_reg <= CNT_LAST);

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer: fixed vector table, directed corner
// sequences and randomized runs against a sliding-window reference model.
module tb_debouncer;

  localparam int STABLE = 4;
  localparam int SYNC   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  debouncer_if dif ();

  debouncer #(
    .STABLE_CYCLES(STABLE),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit in_raw;
    bit exp_out;
    bit exp_rise;
    bit exp_fall;
  } vec_t;

  vec_t vecs[16];

  // Reference: out flips when the last STABLE synchronized samples all
  // differ from it; synchronized sample = raw sample SYNC edges earlier.
  bit raw_hist[$];
  bit m_out, m_rise, m_fall;

  function automatic void model_reset();
    raw_hist.delete();
    for (int i = 0; i < SYNC + STABLE; i++) raw_hist.push_back(1'b0);
    m_out  = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
  endfunction

  function automatic void model_edge(input bit v);
    bit all_differ;
    all_differ = 1'b1;
    raw_hist.push_back(v);
    for (int j = 0; j < STABLE; j++) begin
      if (raw_hist[raw_hist.size() - 1 - SYNC - j] == m_out) all_differ = 1'b0;
    end
    void'(raw_hist.pop_front());
    m_rise = all_differ && !m_out;
    m_fall = all_differ && m_out;
    if (all_differ) m_out = !m_out;
  endfunction

  function automatic logic [2:0] dut_o();
    return {dif.out, dif.rise, dif.fall};
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: out/rise/fall got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One sampling edge: drive, clock, then compare against the model.
  task automatic tick(input bit v, input string name);
    dif.in_raw = v;
    @(posedge clk);
    #1;
    model_edge(v);
    check(name, dut_o(), {m_out, m_rise, m_fall});
  endtask

  // Assert reset between edges, hold it, release on a falling edge.
  task automatic do_reset(input bit raw_level, input int cycles);
    #3;
    rst = 1'b0;
    dif.in_raw = raw_level;
    #1;
    check("rst_async", dut_o(), 3'b000);
    model_reset();
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("rst_hold", dut_o(), 3'b000);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   pattern [8];
    bit   v;
    int   len;
    int   rises;
    logic [2:0] o;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0};

    // Reset values with in_raw held high.
    dif.in_raw = 1'b1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("reset_values", dut_o(), 3'b000);
      $display("reset cycle %0d: out/rise/fall=%b", i, dut_o());
    end
    dif.in_raw = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Clean rise then clean fall from the table.
    for (int i = 0; i < 16; i++) begin
      tick(vecs[i].in_raw, "table_model");
      check($sformatf("table[%0d]", i), dut_o(),
            {vecs[i].exp_out, vecs[i].exp_rise, vecs[i].exp_fall});
      $display("table edge %0d: in=%0b out/rise/fall=%b", i + 1, vecs[i].in_raw, dut_o());
    end

    // Glitch of 3 samples must be rejected.
    for (int e = 1; e <= 23; e++) begin
      tick(e <= 3, "glitch3_model");
      check("glitch3_quiet", dut_o(), 3'b000);
    end
    $display("glitch3: out/rise/fall=%b after 20 quiet cycles", dut_o());

    // Pulse of exactly 4 samples is accepted.
    rises = 0;
    for (int e = 1; e <= 16; e++) begin
      tick(e <= 4, "pulse4_model");
      o = dut_o();
      if (o[1]) rises++;
      if (e == 5) check("pulse4_e5", o, 3'b000);
      if (e == 6) check("pulse4_e6", o, 3'b110);
      if (e == 7) check("pulse4_e7", o, 3'b100);
    end
    check_int("pulse4_rise_count", rises, 1);
    $display("pulse4: rise pulses=%0d", rises);

    // Bounce restarts the window: out rises at edge 8 + SYNC.
    pattern = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rises = 0;
    for (int e = 1; e <= 14; e++) begin
      tick((e <= 8) ? pattern[e-1] : 1'b1, "bounce_model");
      o = dut_o();
      if (o[1]) rises++;
      if (e == 9)  check("bounce_e9", o, 3'b000);
      if (e == 10) check("bounce_e10", o, 3'b110);
      if (e == 11) check("bounce_e11", o, 3'b100);
    end
    check_int("bounce_rise_count", rises, 1);
    $display("bounce: rise pulses=%0d out=%0b", rises, dif.out);

    // Clean fall from out=1.
    for (int e = 1; e <= 8; e++) begin
      tick(1'b0, "fall_model");
      o = dut_o();
      if (e == 5) check("fall_e5", o, 3'b100);
      if (e == 6) check("fall_e6", o, 3'b001);
      if (e == 7) check("fall_e7", o, 3'b000);
    end
    $display("fall: out/rise/fall=%b", dut_o());

    // Reset in the middle of qualification aborts it.
    for (int e = 1; e <= 5; e++) begin
      tick(1'b1, "midrst_model");
      check("midrst_pre", dut_o(), 3'b000);
    end
    do_reset(1'b1, 3);
    for (int e = 1; e <= 8; e++) begin
      tick(1'b1, "midrst_post_model");
      o = dut_o();
      if (e == 5) check("midrst_e5", o, 3'b000);
      if (e == 6) check("midrst_e6", o, 3'b110);
      if (e == 7) check("midrst_e7", o, 3'b100);
    end
    $display("midrst: out/rise/fall=%b after release", dut_o());

    // Randomized runs against the model, with occasional async resets.
    v = 1'b0;
    for (int r = 0; r < 120; r++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 2);
        $display("random run %0d: reset", r);
      end
      v   = ($urandom_range(0, 3) == 0) ? v : !v;
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) tick(v, "random_model");
      $display("random run %0d: in=%0b len=%0d out/rise/fall=%b", r, v, len, dut_o());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
